swipt_drive_ctrl: RTL and testbench

SWIPT_DRIVE_CTRL -- requirements
Module: swipt_drive_ctrl

---
 rtl/swipt_drive_ctrl.sv | 159 +++++++++++++++
 tb/tb_swipt_drive_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/swipt_drive_ctrl.sv
// SWIPT power-stage sequencer: soft-start, frequency search supervision, lock, and phase-accumulator gate drive.
// Define SWIPT_AUTO_RETUNE_EN to add a periodic retune timer while locked.
module swipt_drive_ctrl #(
  parameter logic [19:0] F_INIT        = 20'd100000,
  parameter logic [31:0] PHASE_K       = 32'd43,
  parameter logic [23:0] SETTLE_CYCLES = 24'h30D40,
  parameter logic [23:0] DONE_TIMEOUT  = 24'h989680,
  parameter logic [31:0] RETUNE_PERIOD = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swiptEnable,
  input  logic        retune,
  input  logic [19:0] newFreq,
  input  logic [19:0] bestFreq,
  input  logic        freqAlgDone,
  output logic        swiptAlive,
  output logic        freqAlgGo,
  output logic [19:0] freq,
  output logic [19:0] driveFreq,
  output logic        drive,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SOFTSTART, SEARCH, LOCK} state_t;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_settle, r_tcnt;
  logic        r_armed, r_timeout;
  logic [19:0] r_freq, r_drive_freq;
  logic [31:0] r_acc;
  logic [31:0] w_inc;
  logic        w_done, w_tmo_hit, w_search_load, w_retune_req;

  assign w_inc = 32'(r_drive_freq) * PHASE_K;

`ifdef SWIPT_AUTO_RETUNE_EN
  logic [31:0] r_rcnt;

  assign w_retune_req = retune | (r_rcnt <= 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
    end else if (r_state != LOCK && w_state_nxt == LOCK) begin
      r_rcnt <= RETUNE_PERIOD;
    end else if (r_state == LOCK && r_rcnt != '0) begin
      r_rcnt <= r_rcnt - 32'd1;
    end
  end
`else
  assign w_retune_req = retune;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Disable overrides every other event; completion beats timeout expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_done        = 1'b0;
    w_tmo_hit     = 1'b0;
    w_search_load = 1'b0;
    swiptAlive    = (r_state != IDLE);
    freqAlgGo     = (r_state == SEARCH);
    locked        = (r_state == LOCK);
    if (!swiptEnable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = SOFTSTART;
        SOFTSTART: begin
          if (r_settle == '0) begin
            w_state_nxt   = SEARCH;
            w_search_load = 1'b1;
          end
        end
        SEARCH: begin
          if (r_armed && freqAlgDone) begin
            w_done      = 1'b1;
            w_state_nxt = LOCK;
          end else if (r_tcnt <= 24'd1) begin
            w_tmo_hit   = 1'b1;
            w_state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (w_retune_req) begin
            w_state_nxt   = SEARCH;
            w_search_load = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle     <= '0;
      r_tcnt       <= '0;
      r_armed      <= 1'b0;
      r_timeout    <= 1'b0;
      r_freq       <= F_INIT;
      r_drive_freq <= F_INIT;
      r_acc        <= '0;
    end else if (!swiptEnable) begin
      r_settle     <= '0;
      r_tcnt       <= '0;
      r_armed      <= 1'b0;
      r_freq       <= F_INIT;
      r_drive_freq <= F_INIT;
      r_acc        <= '0;
    end else begin
      if (r_state != IDLE) r_acc <= r_acc + w_inc;
      case (r_state)
        IDLE: r_settle <= SETTLE_CYCLES;
        SOFTSTART: begin
          r_drive_freq <= r_freq;
          if (r_settle != '0) r_settle <= r_settle - 24'd1;
        end
        SEARCH: begin
          if (w_done) begin
            if (bestFreq != '0) begin
              r_freq       <= bestFreq;
              r_drive_freq <= bestFreq;
            end else begin
              r_drive_freq <= r_freq;
            end
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_freq    <= r_drive_freq;
          end else begin
            r_tcnt <= r_tcnt - 24'd1;
            if (!freqAlgDone)     r_armed      <= 1'b1;
            if (newFreq != '0)    r_drive_freq <= newFreq;
          end
        end
        LOCK: r_drive_freq <= r_freq;
        default: r_drive_freq <= r_freq;
      endcase
      // Entering a search restarts the timeout window and forgets any stale done.
      if (w_search_load) begin
        r_tcnt    <= DONE_TIMEOUT;
        r_armed   <= 1'b0;
        r_timeout <= 1'b0;
      end
    end
  end

  assign freq      = r_freq;
  assign driveFreq = r_drive_freq;
  assign drive     = r_acc[31];
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_swipt_drive_ctrl.sv
// Randomised bench for swipt_drive_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_swipt_drive_ctrl;

  localparam logic [19:0] F_INIT = 20'd100000;
  localparam int SETTLE = 16;
  localparam int DTMO   = 100;
  localparam int RPER   = 200;
  localparam logic [31:0] PK = 32'd43;
`ifdef SWIPT_AUTO_RETUNE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_OFF = 0, M_SOFT = 1, M_SRCH = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic swiptEnable = 1'b0, retune = 1'b0, freqAlgDone = 1'b0;
  logic [19:0] newFreq = '0, bestFreq = '0;
  logic swiptAlive, freqAlgGo, drive, locked, timeout;
  logic [19:0] freq, driveFreq;

  int n_cmp = 0;
  int n_bad = 0;

  swipt_drive_ctrl #(
    .SETTLE_CYCLES(24'd16), .DONE_TIMEOUT(24'd100), .RETUNE_PERIOD(32'd200)
  ) dut (
    .clk(clk), .rst(rst), .swiptEnable(swiptEnable), .retune(retune),
    .newFreq(newFreq), .bestFreq(bestFreq), .freqAlgDone(freqAlgDone),
    .swiptAlive(swiptAlive), .freqAlgGo(freqAlgGo), .freq(freq),
    .driveFreq(driveFreq), .drive(drive), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase mode plus cycles elapsed in it.
  int          mode = M_OFF;
  int          el = 0;
  logic        seen = 1'b0;
  logic        m_to = 1'b0;
  logic [19:0] m_freq = F_INIT;
  logic [19:0] m_dfreq = F_INIT;
  logic [31:0] m_acc = '0;

  always @(posedge clk or posedge rst) begin : mdl
    int nm, ne;
    logic ns, nt;
    logic [19:0] nf, nd;
    logic [31:0] na;
    if (rst) begin
      mode <= M_OFF; el <= 0; seen <= 1'b0; m_to <= 1'b0;
      m_freq <= F_INIT; m_dfreq <= F_INIT; m_acc <= '0;
    end else begin
      nm = mode; ne = el; ns = seen; nt = m_to; nf = m_freq; nd = m_dfreq;
      na = (mode != M_OFF) ? m_acc + 32'(m_dfreq) * PK : m_acc;
      if (!swiptEnable) begin
        nm = M_OFF; nf = F_INIT; nd = F_INIT; na = '0;
      end else begin
        case (mode)
          M_OFF: begin nm = M_SOFT; ne = 0; end
          M_SOFT: begin
            nd = m_freq;
            if (el == SETTLE) begin nm = M_SRCH; ne = 0; ns = 1'b0; nt = 1'b0; end
            else ne = el + 1;
          end
          M_SRCH: begin
            if (seen && freqAlgDone) begin
              if (bestFreq != '0) begin nf = bestFreq; nd = bestFreq; end
              else nd = m_freq;
              nm = M_LOCK; ne = 0;
            end else if (el + 1 == DTMO) begin
              nt = 1'b1; nf = m_dfreq; nm = M_LOCK; ne = 0;
            end else begin
              ne = el + 1;
              if (!freqAlgDone) ns = 1'b1;
              if (newFreq != '0) nd = newFreq;
            end
          end
          default: begin
            nd = m_freq; ne = el + 1;
            if (retune || (AUTO && el + 1 == RPER)) begin
              nm = M_SRCH; ne = 0; ns = 1'b0; nt = 1'b0;
            end
          end
        endcase
      end
      mode <= nm; el <= ne; seen <= ns; m_to <= nt;
      m_freq <= nf; m_dfreq <= nd; m_acc <= na;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic [44:0] act, exp;
    act = {swiptAlive, freqAlgGo, locked, timeout, drive, freq, driveFreq};
    exp = {(mode != M_OFF), (mode == M_SRCH), (mode == M_LOCK), m_to, m_acc[31], m_freq, m_dfreq};
    n_cmp++;
    if (act !== exp || (freqAlgGo && locked)) begin
      n_bad++;
      $display("FAIL model_cycle: got %h, want %h {alive,go,locked,timeout,drive,freq,driveFreq} (t=%0t)",
               act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [19:0] rnd_freq();
    return 20'($urandom_range(80000, 120000));
  endfunction

  initial begin
    int n, cnt;
    logic [19:0] lastnz, prevnz, bf;
    logic pd;
    @(posedge clk); #2;
    tick();
    chk("rst_alive", swiptAlive, 0); chk("rst_go", freqAlgGo, 0);
    chk("rst_freq", freq, F_INIT); chk("rst_dfreq", driveFreq, F_INIT);
    chk("rst_drive", drive, 0); chk("rst_locked", locked, 0); chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick();
    chk("idle_alive", swiptAlive, 0);

    swiptEnable = 1'b1; freqAlgDone = 1'b1; newFreq = 20'd99000;
    tick();
    chk("alive_next", swiptAlive, 1);
    n = 0;
    while (!freqAlgGo && n < 40) begin
      chk("soft_dfreq", driveFreq, F_INIT);
      tick(); n++;
    end
    chk("go_latency", n, 17);

    // Stale done held from the start must not complete the search.
    repeat (5) begin newFreq = rnd_freq(); tick(); end
    chk("stale_done_ignored", locked, 0);
    freqAlgDone = 1'b0; tick();
    freqAlgDone = 1'b1; bestFreq = 20'd98500; tick();
    chk("done_locked", locked, 1); chk("done_go", freqAlgGo, 0);
    chk("done_freq", freq, 98500); chk("done_dfreq", driveFreq, 98500);
    chk("done_timeout", timeout, 0);

    // Search with done held low runs to timeout.
    freqAlgDone = 1'b0; retune = 1'b1; tick(); retune = 1'b0;
    chk("retune_go", freqAlgGo, 1);
    lastnz = 20'd98500; prevnz = lastnz; n = 0;
    while (n < 150) begin
      newFreq = ($urandom_range(0, 3) == 0) ? 20'd0 : rnd_freq();
      prevnz = lastnz;
      if (newFreq != '0) lastnz = newFreq;
      tick(); n++;
      if (locked) break;
    end
    chk("tmo_cycles", n, DTMO); chk("tmo_flag", timeout, 1);
    chk("tmo_freq", freq, prevnz); chk("tmo_locked", locked, 1);

    // Armed done arriving on the expiry cycle wins.
    retune = 1'b1; tick(); retune = 1'b0;
    chk("reentry_timeout_clr", timeout, 0);
    for (int k = 0; k < DTMO - 1; k++) begin newFreq = rnd_freq(); tick(); end
    chk("no_early_lock", locked, 0);
    bf = rnd_freq(); freqAlgDone = 1'b1; bestFreq = bf; tick();
    chk("race_locked", locked, 1); chk("race_timeout", timeout, 0); chk("race_freq", freq, bf);

    // Lock at 100 kHz and watch the drive waveform.
    freqAlgDone = 1'b0; retune = 1'b1; tick(); retune = 1'b0; tick();
    freqAlgDone = 1'b1; bestFreq = 20'd100000; tick();
    chk("lock100k", locked, 1);
`ifdef SWIPT_AUTO_RETUNE_EN
    n = 0;
    while (locked && n < 400) begin tick(); n++; end
    chk("auto_retune_cycles", n, RPER); chk("auto_retune_go", freqAlgGo, 1);
`else
    cnt = 0; pd = drive;
    for (int k = 0; k < 10000; k++) begin
      tick();
      if (drive && !pd) cnt++;
      pd = drive;
    end
    chk("drive_periods_10k", (cnt >= 9 && cnt <= 11), 1);
`endif

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      swiptEnable = ($urandom_range(0, 99) != 0);
      retune      = ($urandom_range(0, 29) == 0);
      case ((i / 250) % 3)
        0:       freqAlgDone = 1'b0;
        1:       freqAlgDone = ($urandom_range(0, 19) == 0);
        default: freqAlgDone = 1'($urandom_range(0, 1));
      endcase
      newFreq  = ($urandom_range(0, 4) == 0) ? 20'd0 : 20'($urandom_range(1, 1048575));
      bestFreq = ($urandom_range(0, 4) == 0) ? 20'd0 : 20'($urandom_range(1, 1048575));
      tick();
    end
    retune = 1'b0;

    // Disable and retune in the same cycle during search.
    swiptEnable = 1'b0; tick(); swiptEnable = 1'b1; freqAlgDone = 1'b0;
    n = 0;
    while (!freqAlgGo && n < 60) begin tick(); n++; end
    chk("reach_search", freqAlgGo, 1);
    repeat (3) tick();
    swiptEnable = 1'b0; retune = 1'b1; tick(); retune = 1'b0;
    chk("dis_go", freqAlgGo, 0); chk("dis_drive", drive, 0);
    chk("dis_alive", swiptAlive, 0); chk("dis_freq", freq, F_INIT);

    // Reset mid-search drops the enable at once.
    swiptEnable = 1'b1;
    n = 0;
    while (!freqAlgGo && n < 60) begin tick(); n++; end
    #1 rst = 1'b1; #1;
    chk("rst_search_go", freqAlgGo, 0);
    tick(); rst = 1'b0;
    n = 0;
    while (!freqAlgGo && n < 60) begin tick(); n++; end
    chk("resume_go", freqAlgGo, 1);

    // Reset mid-lock after a timeout clears everything at once.
    n = 0;
    while (!locked && n < 150) begin newFreq = rnd_freq(); tick(); n++; end
    chk("pre_rst_timeout", timeout, 1);
    repeat (3) tick();
    #1 rst = 1'b1; #1;
    chk("arst_locked", locked, 0); chk("arst_alive", swiptAlive, 0);
    chk("arst_go", freqAlgGo, 0); chk("arst_freq", freq, F_INIT);
    chk("arst_dfreq", driveFreq, F_INIT); chk("arst_drive", drive, 0);
    chk("arst_timeout", timeout, 0);
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_alive", swiptAlive, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
